// File: rtl/i2s_rx.sv
// I2S (Philips) stereo receiver.
// The pad signals are oversampled by the system clock and bit-clock edges are
// recovered from them. Complete left/right words are assembled MSB-first,
// truncated or zero-padded to WIDTH, and queued as pairs in a 2-deep FIFO with
// a sticky overrun flag.
module i2s_rx #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             io_rst,
  input  logic             en,
  input  logic             io_i2s_lrclk,
  input  logic             io_i2s_bclk,
  input  logic             io_i2s_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_left,
  output logic [WIDTH-1:0] o_right,
  output logic             o_overrun,
  input  logic             clr_ovr
);

  localparam int unsigned     CntW   = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

  typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

  state_e state_q, state_d;

  logic bclk_s1_q, bclk_s2_q, bclk_hist_q;
  logic lrclk_s1_q, lrclk_s2_q;
  logic data_s1_q, data_s2_q;
  logic ws_q;

  logic             bclk_rise;
  logic             boundary;
  logic [CntW-1:0]  cnt_q, cnt_inc;
  logic [WIDTH-1:0] sh_q, word;
  logic [WIDTH-1:0] left_hold_q;
  logic             left_ok_q;
  logic             push, store_left;

  logic [2*WIDTH-1:0] mem_q [2];
  logic               rd_ptr_q, wr_ptr_q;
  logic [1:0]         fifo_cnt_q;
  logic               pop, full, do_push, ovr_set;

  // Two-flop synchronizers for all pad inputs, plus bclk history for edge detect.
  always_ff @(posedge clk) begin
    if (io_rst) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_hist_q <= 1'b0;
      lrclk_s1_q  <= 1'b0;
      lrclk_s2_q  <= 1'b0;
      data_s1_q   <= 1'b0;
      data_s2_q   <= 1'b0;
    end else begin
      bclk_s1_q   <= io_i2s_bclk;
      bclk_s2_q   <= bclk_s1_q;
      bclk_hist_q <= bclk_s2_q;
      lrclk_s1_q  <= io_i2s_lrclk;
      lrclk_s2_q  <= lrclk_s1_q;
      data_s1_q   <= io_i2s_data;
      data_s2_q   <= data_s1_q;
    end
  end

  assign bclk_rise = bclk_s2_q & ~bclk_hist_q;
  // ws_q holds the word select of the previous edge, so a mismatch marks the
  // LSB slot of the channel named by ws_q.
  assign boundary  = bclk_rise & (lrclk_s2_q != ws_q);

  // Word-select tracking; runs regardless of enable so locking sees true edges.
  always_ff @(posedge clk) begin
    if (io_rst) begin
      ws_q <= 1'b0;
    end else if (bclk_rise) begin
      ws_q <= lrclk_s2_q;
    end
  end

  // Place the current bit at its left-aligned position; beyond WIDTH it is dropped.
  always_comb begin
    word    = sh_q;
    cnt_inc = cnt_q;
    if (cnt_q < CntMax) begin
      cnt_inc = cnt_q + CntW'(1);
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (i == int'(WIDTH) - 1 - int'(cnt_q)) word[i] = data_s2_q;
      end
    end
  end

  // Lock state and word routing decisions.
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    store_left = 1'b0;
    case (state_q)
      StUnlocked: begin
        // The word finishing at the locking boundary is partial; discard it.
        if (en && boundary) state_d = StLocked;
      end
      StLocked: begin
        if (!en) begin
          state_d = StUnlocked;
        end else if (boundary) begin
          if (!ws_q) store_left = 1'b1;
          else if (left_ok_q) push = 1'b1;
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (io_rst) state_q <= StUnlocked;
    else        state_q <= state_d;
  end

  // Bit counter, shift register and left-pending flag; held cleared when disabled.
  always_ff @(posedge clk) begin
    if (io_rst || !en) begin
      cnt_q     <= '0;
      sh_q      <= '0;
      left_ok_q <= 1'b0;
    end else begin
      if (bclk_rise) begin
        if (boundary) begin
          cnt_q <= '0;
          sh_q  <= '0;
        end else begin
          cnt_q <= cnt_inc;
          sh_q  <= word;
        end
      end
      if (store_left)  left_ok_q <= 1'b1;
      else if (push)   left_ok_q <= 1'b0;
    end
  end

  // Holding register for the finished left word awaiting its right partner.
  always_ff @(posedge clk) begin
    if (io_rst)          left_hold_q <= '0;
    else if (store_left) left_hold_q <= word;
  end

  assign pop     = o_valid & i_ready;
  assign full    = (fifo_cnt_q == 2'd2);
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  // Two-entry pair FIFO.
  always_ff @(posedge clk) begin
    if (io_rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= {left_hold_q, word};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Sticky overrun; a new overrun wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (io_rst)       o_overrun <= 1'b0;
    else if (ovr_set) o_overrun <= 1'b1;
    else if (clr_ovr) o_overrun <= 1'b0;
  end

  assign o_valid = (fifo_cnt_q != 2'd0);
  assign o_left  = o_valid ? mem_q[rd_ptr_q][2*WIDTH-1:WIDTH] : '0;
  assign o_right = o_valid ? mem_q[rd_ptr_q][WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: directed Philips I2S frames, expected pairs
// queued at stimulus time and checked by an independent output monitor.
module tb_i2s_rx;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             io_rst, en, lrclk, bclk, sdata;
  logic             o_valid, i_ready, o_overrun, clr_ovr;
  logic [WIDTH-1:0] o_left, o_right;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic        carry;

  i2s_rx #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .io_rst       (io_rst),
    .en           (en),
    .io_i2s_lrclk (lrclk),
    .io_i2s_bclk  (bclk),
    .io_i2s_data  (sdata),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_left       (o_left),
    .o_right      (o_right),
    .o_overrun    (o_overrun),
    .clr_ovr      (clr_ovr)
  );

  always #5 clk = ~clk;

  // Inputs change 2 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One bclk period of 8 clk: 4 low, 4 high.
  task automatic send_bit(input logic ws, input logic b);
    bclk  = 1'b0;
    lrclk = ws;
    sdata = b;
    ticks(4);
    bclk = 1'b1;
    ticks(4);
  endtask

  // Philips framing: the first bit of a slot carries the previous word's LSB.
  task automatic send_slot(input logic ws, input logic [31:0] w, input int s, input int nbits);
    for (int k = 0; k < nbits; k++) send_bit(ws, (k == 0) ? carry : w[s-k]);
    carry = w[0];
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int s);
    send_slot(1'b0, l, s, s);
    send_slot(1'b1, r, s, s);
  endtask

  task automatic close_stream();
    send_bit(1'b0, carry);
    ticks(8);
  endtask

  task automatic start_stream();
    en = 1'b0;
    ticks(3);
    en    = 1'b1;
    carry = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Output monitor: every accepted pair must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!io_rst && o_valid && i_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pair: got 0x%0h_%0h, expected no pair", o_left, o_right);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({o_left, o_right} !== mon_exp) begin
          fails++;
          $display("FAIL pair: got 0x%0h_%0h, expected 0x%0h_%0h",
                   o_left, o_right, mon_exp[31:16], mon_exp[15:0]);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    io_rst  = 1'b1;
    en      = 1'b0;
    lrclk   = 1'b0;
    bclk    = 1'b0;
    sdata   = 1'b0;
    i_ready = 1'b1;
    clr_ovr = 1'b0;
    carry   = 1'b0;
    ticks(5);
    check("rst_valid",   o_valid,   0);
    check("rst_left",    o_left,    0);
    check("rst_right",   o_right,   0);
    check("rst_overrun", o_overrun, 0);
    io_rst = 1'b0;
    ticks(2);

    // Two full frames after a lock frame, consumer always ready.
    start_stream();
    send_frame(32'h1111, 32'h2222, 16);
    exp_q.push_back(32'h1234_ABCD);
    send_frame(32'h1234, 32'hABCD, 16);
    exp_q.push_back(32'h8001_7FFE);
    send_frame(32'h8001, 32'h7FFE, 16);
    close_stream();
    wait_drain("basic_drain");
    check("basic_no_overrun", o_overrun, 0);

    // Long slots truncate, short slots left-align with zero fill.
    start_stream();
    send_frame(32'h1111, 32'h2222, 16);
    exp_q.push_back(32'hA5A5_0F0F);
    send_frame(32'hA5A5FF, 32'h0F0F00, 24);
    exp_q.push_back(32'hFFF0_8010);
    send_frame(32'hFFF, 32'h801, 12);
    close_stream();
    wait_drain("width_drain");

    // Stalled consumer: third pair overruns, FIFO keeps the first two.
    i_ready = 1'b0;
    start_stream();
    send_frame(32'h1111, 32'h2222, 16);
    exp_q.push_back(32'h1357_2468);
    exp_q.push_back(32'h9ABC_DEF0);
    send_frame(32'h1357, 32'h2468, 16);
    send_frame(32'h9ABC, 32'hDEF0, 16);
    send_frame(32'h5555, 32'hAAAA, 16);
    close_stream();
    check("ovr_valid",   o_valid,   1);
    check("ovr_head_l",  o_left,    32'h1357);
    check("ovr_head_r",  o_right,   32'h2468);
    check("ovr_set",     o_overrun, 1);
    en = 1'b0;
    ticks(2);
    check("ovr_kept_en0",   o_overrun, 1);
    check("valid_kept_en0", o_valid,   1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_cleared", o_overrun, 0);
    i_ready = 1'b1;
    wait_drain("ovr_drain");
    check("ovr_empty", o_valid, 0);

    // Reset in the middle of a right word drops that pair and relocks.
    start_stream();
    send_frame(32'h1111, 32'h2222, 16);
    exp_q.push_back(32'h4321_8765);
    send_frame(32'h4321, 32'h8765, 16);
    send_slot(1'b0, 32'hCAFE, 16, 16);
    send_slot(1'b1, 32'hBEEF, 16, 8);
    bclk = 1'b0;
    tick();
    io_rst = 1'b1;
    ticks(3);
    check("midrst_valid", o_valid, 0);
    io_rst = 1'b0;
    ticks(2);
    send_slot(1'b1, 32'h00FF, 16, 8);
    exp_q.push_back(32'h1020_3040);
    send_frame(32'h1020, 32'h3040, 16);
    close_stream();
    wait_drain("midrst_drain");

    // Stream joined mid-frame on the right channel.
    start_stream();
    send_slot(1'b1, 32'h5A5A, 16, 8);
    exp_q.push_back(32'h0102_F0E0);
    send_frame(32'h0102, 32'hF0E0, 16);
    close_stream();
    wait_drain("midframe_drain");
    check("final_overrun", o_overrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
